// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes, select codes and state encoding for the mul/div sequencer
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [2:0] SEL_DIV   = 3'd2;
    localparam logic [2:0] SEL_DIVU  = 3'd3;
    localparam logic [2:0] SEL_MUL   = 3'd4;
    localparam logic [2:0] SEL_MULTU = 3'd5;
    localparam logic [2:0] SEL_RS    = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_MUL_WAIT   = 3'd1,
        ST_DIV_LAUNCH = 3'd2,
        ST_DIV_WAIT   = 3'd3,
        ST_WRITE      = 3'd4
    } state_t;

    // HI/LO source for each legal operation; MTHI/MTLO both take rs
    function automatic logic [2:0] sel_for_op(input logic [2:0] op);
        case (op)
            OP_MULT:  return SEL_MUL;
            OP_MULTU: return SEL_MULTU;
            OP_DIV:   return SEL_DIV;
            OP_DIVU:  return SEL_DIVU;
            default:  return SEL_RS;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_timer.sv
// rtl/muldiv_timer.sv - 6-bit wait-cycle counter with load and terminal compare
module muldiv_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [5:0] limit,
    output logic       at_limit
);

    logic [5:0] count;

    // Counts cycles spent in the current wait state; the first wait cycle reads 1
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 6'd0;
        end else if (load) begin
            count <= 6'd1;
        end else if (en) begin
            count <= count + 6'd1;
        end
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - sequences MULT/DIV units and HI/LO writes for the multicycle CPU
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT     = 2,
    parameter int DIV_TIMEOUT = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [2:0] op,
    input  logic       divisor_zero,
    input  logic       div_busy,
    output logic       div_start,
    output logic       hi_ena,
    output logic       lo_ena,
    output logic [2:0] hi_sel,
    output logic [2:0] lo_sel,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [5:0] MUL_LIMIT = 6'(MUL_LAT);
    localparam logic [5:0] DIV_LIMIT = 6'(DIV_TIMEOUT);

    state_t     state, state_nx;
    logic [2:0] op_q;
    logic       nowrite_q;
    logic       seen_busy_q;
    logic       timer_load;
    logic       timer_en;
    logic       at_limit;
    logic       timeout;
    logic       accept;
    logic       is_div_op;

    assign accept    = req && (op <= OP_MTLO);
    assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);

    muldiv_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .en       (timer_en),
        .limit    ((state == ST_DIV_WAIT) ? DIV_LIMIT : MUL_LIMIT),
        .at_limit (at_limit)
    );

    // State, latched request and the no-write / divider-busy-seen flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_q        <= 3'd0;
            nowrite_q   <= 1'b0;
            seen_busy_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && accept) begin
                op_q      <= op;
                nowrite_q <= is_div_op && divisor_zero;
            end else if (timeout) begin
                nowrite_q <= 1'b1;
            end
            if (state == ST_DIV_LAUNCH) begin
                seen_busy_q <= 1'b0;
            end else if (state == ST_DIV_WAIT && div_busy) begin
                seen_busy_q <= 1'b1;
            end
        end
    end

    // Next state, timer control and Moore outputs decoded from registered state
    always_comb begin
        state_nx   = state;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        timeout    = 1'b0;
        div_start  = 1'b0;
        hi_ena     = 1'b0;
        lo_ena     = 1'b0;
        hi_sel     = 3'd0;
        lo_sel     = 3'd0;
        done       = 1'b0;
        err        = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (op == OP_MULT || op == OP_MULTU) begin
                        state_nx   = ST_MUL_WAIT;
                        timer_load = 1'b1;
                    end else if (is_div_op && !divisor_zero) begin
                        state_nx = ST_DIV_LAUNCH;
                    end else begin
                        state_nx = ST_WRITE;
                    end
                end
            end
            ST_MUL_WAIT: begin
                timer_en = 1'b1;
                if (at_limit) state_nx = ST_WRITE;
            end
            ST_DIV_LAUNCH: begin
                div_start  = 1'b1;
                timer_load = 1'b1;
                state_nx   = ST_DIV_WAIT;
            end
            ST_DIV_WAIT: begin
                timer_en = 1'b1;
                // A completion seen in the same cycle as the limit still wins
                if (seen_busy_q && !div_busy) begin
                    state_nx = ST_WRITE;
                end else if (at_limit) begin
                    state_nx = ST_WRITE;
                    timeout  = 1'b1;
                end
            end
            ST_WRITE: begin
                done     = 1'b1;
                err      = nowrite_q;
                hi_ena   = !nowrite_q && (op_q != OP_MTLO);
                lo_ena   = !nowrite_q && (op_q != OP_MTHI);
                hi_sel   = sel_for_op(op_q);
                lo_sel   = sel_for_op(op_q);
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - randomized self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

    localparam int MUL_LAT     = 2;
    localparam int DIV_TIMEOUT = 40;

    logic       clk = 1'b0;
    logic       rst, req, divisor_zero, div_busy;
    logic [2:0] op;
    logic       div_start, hi_ena, lo_ena, busy, done, err;
    logic [2:0] hi_sel, lo_sel;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.MUL_LAT(MUL_LAT), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .divisor_zero(divisor_zero),
        .div_busy(div_busy), .div_start(div_start), .hi_ena(hi_ena), .lo_ena(lo_ena),
        .hi_sel(hi_sel), .lo_sel(lo_sel), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Output vector order: busy, div_start, done, err, hi_ena, lo_ena, hi_sel, lo_sel
    function automatic logic [11:0] outs();
        return {busy, div_start, done, err, hi_ena, lo_ena, hi_sel, lo_sel};
    endfunction

    function automatic logic [2:0] ref_sel(input logic [2:0] o);
        logic [2:0] t [0:5];
        t[0] = 3'd4; t[1] = 3'd5; t[2] = 3'd2; t[3] = 3'd3; t[4] = 3'd6; t[5] = 3'd6;
        return t[o];
    endfunction

    // One full operation: req in cycle 0, done expected in cycle L. blen is how many
    // cycles the divider stays busy after its launch cycle (0 = never busy).
    // extra > 0 injects a second request in that cycle, which must be ignored.
    task automatic run_op(input string name, input logic [2:0] o, input logic dz,
                          input int blen, input int extra);
        bit is_div, is_mul, timed_out, e;
        int L;
        logic [11:0] exp_v, got;
        is_div    = (o == 3'd2 || o == 3'd3);
        is_mul    = (o == 3'd0 || o == 3'd1);
        timed_out = is_div && !dz && blen == 0;
        e         = (is_div && dz) || timed_out;
        if (is_mul)               L = MUL_LAT + 1;
        else if (!is_div || dz)   L = 1;
        else if (timed_out)       L = DIV_TIMEOUT + 2;
        else                      L = blen + 3;
        for (int c = 0; c <= L; c++) begin
            req          = (c == 0) || (extra > 0 && c == extra);
            op           = (c == 0) ? o : 3'($urandom_range(0, 5));
            divisor_zero = (c == 0) ? dz : 1'($urandom);
            div_busy     = is_div && !dz && c >= 2 && c <= 1 + blen;
            @(negedge clk);
            exp_v = '0;
            exp_v[11] = (c >= 1);
            exp_v[10] = is_div && !dz && c == 1;
            if (c == L) begin
                exp_v[9] = 1'b1;
                exp_v[8] = e;
                exp_v[7] = !e && o != 3'd5;
                exp_v[6] = !e && o != 3'd4;
                exp_v[5:3] = ref_sel(o);
                exp_v[2:0] = ref_sel(o);
            end
            got = outs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL %s op=%0d cycle %0d: got %b expected %b", name, o, c, got, exp_v);
            end
            @(posedge clk); #1;
        end
        req = 1'b0;
        div_busy = 1'b0;
    endtask

    task automatic expect_idle(input string name, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            checks++;
            if (outs() !== 12'd0) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b expected %b", name, c, outs(), 12'd0);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b1; op = 3'd4; divisor_zero = 1'b0; div_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_idle("reset_hold", 2);
        rst = 1'b0; req = 1'b0;
        expect_idle("reset_release", 2);
    endtask

    task automatic test_move();
        run_op("mthi", 3'd4, 1'b0, 0, 0);
        run_op("mtlo", 3'd5, 1'b1, 0, 0);
        expect_idle("move_after", 1);
    endtask

    task automatic test_mult();
        run_op("multu", 3'd1, 1'b0, 0, 2);
        run_op("mult", 3'd0, 1'b1, 0, 1);
        expect_idle("mult_after", 1);
    endtask

    task automatic test_div();
        run_op("div_33", 3'd2, 1'b0, 33, 10);
        run_op("divu_1", 3'd3, 1'b0, 1, 0);
        expect_idle("div_after", 1);
    endtask

    task automatic test_div_zero();
        run_op("divu_zero", 3'd3, 1'b1, 0, 0);
        run_op("div_zero", 3'd2, 1'b1, 0, 1);
        expect_idle("div_zero_after", 1);
    endtask

    task automatic test_timeout();
        run_op("div_timeout", 3'd2, 1'b0, 0, 7);
        run_op("mtlo_after_timeout", 3'd5, 1'b0, 0, 0);
    endtask

    task automatic test_reset_midop();
        req = 1'b1; op = 3'd2; divisor_zero = 1'b0;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        div_busy = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        div_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (outs() !== 12'd0) begin
            errors++;
            $display("FAIL reset_midop: got %b expected %b", outs(), 12'd0);
        end
        @(posedge clk); #1;
        expect_idle("reset_midop_idle", 2);
        run_op("mthi_after_reset", 3'd4, 1'b0, 0, 0);
    endtask

    task automatic test_illegal();
        for (int k = 6; k <= 7; k++) begin
            req = 1'b1; op = 3'(k); divisor_zero = 1'($urandom);
            @(posedge clk); #1;
            req = 1'b0;
            expect_idle("illegal_op", 3);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 24; n++) begin
            logic [2:0] o;
            logic dz;
            int blen;
            o    = 3'($urandom_range(0, 5));
            dz   = 1'($urandom_range(0, 3) == 0);
            blen = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 30));
            run_op("back_to_back", o, dz, blen, int'($urandom_range(0, 2)));
        end
        expect_idle("b2b_after", 1);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; op = 3'd0; divisor_zero = 1'b0; div_busy = 1'b0;
        test_reset();
        test_move();
        test_mult();
        test_div();
        test_div_zero();
        test_timeout();
        test_reset_midop();
        test_illegal();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences the shared multiply/divide resources (DIV, DIVU, MULT, MULTU) and the HI/LO registers for the multicycle CPU.
- Accepts one operation request from control_unit, launches the unit, waits for its result, then drives the HI/LO write enables and source selects for exactly one cycle.
- Holds `busy` high for the whole operation so control_unit can stall its FSM.

Parameters:
- MUL_LAT, 2: cycles from operand capture until the MULT/MULTU outputs are valid; legal range 1..15.
- DIV_TIMEOUT, 40: maximum number of DIV_WAIT cycles before the operation is aborted.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  operation request; sampled only in IDLE.
- op  input  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are illegal.
- divisor_zero  input  1  rt == 0; sampled together with req.
- div_busy  input  1  busy flag from the DIV/DIVU cores.
- div_start  output  1  one-cycle launch pulse to DIV/DIVU.
- hi_ena  output  1  HI write enable.
- lo_ena  output  1  LO write enable.
- hi_sel  output  3  HI source select: 2 div remainder, 3 divu remainder, 4 mult, 5 multu, 6 rs.
- lo_sel  output  3  LO source select, same encoding as hi_sel.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  qualifies done: divide-by-zero or timeout.

Behaviour:
- Reset (synchronous, active-high): state returns to IDLE and counters clear. All outputs are 0 from the first clock edge with rst high. Reset overrides any operation in flight and overrides req; no HI/LO write occurs.
- States: IDLE, MUL_WAIT, DIV_LAUNCH, DIV_WAIT, WRITE. All outputs are registered (Moore), so each output reflects the current state.
- IDLE:
  - With req=1 and a legal op at edge T, latch op and divisor_zero.
  - op 0/1 -> MUL_WAIT with count=1.
  - op 2/3 with divisor_zero=0 -> DIV_LAUNCH.
  - op 2/3 with divisor_zero=1 -> WRITE with the no-write flag set and err=1.
  - op 4/5 -> WRITE.
  - Illegal op: request ignored, state stays IDLE, busy stays 0, no done.
- MUL_WAIT: increment count each cycle. When count == MUL_LAT, go to WRITE.
- DIV_LAUNCH: div_start=1 for exactly one cycle, then DIV_WAIT with the timer cleared and the seen_busy flag cleared.
- DIV_WAIT:
  - Set seen_busy when div_busy=1.
  - When seen_busy=1 and div_busy=0, go to WRITE.
  - If the timer reaches DIV_TIMEOUT first, go to WRITE with no-write and err=1.
  - A busy that never rises also ends in timeout.
- WRITE: lasts one cycle, then return to IDLE. Outputs in WRITE:
  - done=1.
  - hi_ena/lo_ena per op: MULT/MULTU/DIV/DIVU set both; MTHI sets hi_ena only; MTLO sets lo_ena only. No-write forces both to 0.
  - hi_sel = lo_sel = 4 (MULT), 5 (MULTU), 2 (DIV), 3 (DIVU), 6 (MTHI/MTLO).
  - Selects are 0 in every other state.
- Latency from the req edge to the done cycle:
  - MTHI/MTLO: 1.
  - MULT/MULTU: MUL_LAT + 1.
  - DIV/DIVU: divider busy time + 3.
  - Divide-by-zero: 1.
  - Timeout: DIV_TIMEOUT + 2.
- req while busy=1 is ignored. It is not queued and has no effect on the current operation.
- The first new req is accepted in the cycle after WRITE, when the state is back in IDLE.

Decomposition:
- Shared package muldiv_pkg holds: op codes (OP_MULT..OP_MTLO), select codes (SEL_DIV=2, SEL_DIVU=3, SEL_MUL=4, SEL_MULTU=5, SEL_RS=6), and the state encoding.
- One sub-module, muldiv_timer: a 6-bit up-counter with clear and terminal-compare. It is shared by MUL_WAIT (compare to MUL_LAT) and DIV_WAIT (compare to DIV_TIMEOUT).

Test Plan:
1. MTHI: req=1, op=4 at cycle 0 -> cycle 1: done=1, hi_ena=1, lo_ena=0, hi_sel=6, busy=1; cycle 2: busy=0.
2. MULTU with MUL_LAT=2: req at cycle 0 -> busy 1..3; done, hi_ena, lo_ena and sel=5 all in cycle 3; nothing else in between.
3. DIV with a model holding div_busy high for 33 cycles after div_start -> div_start only in cycle 1; done in cycle 36 with sel=2, err=0. A second req in cycle 10 is ignored.
4. DIVU with divisor_zero=1 -> cycle 1: done=1, err=1, hi_ena=lo_ena=0, div_start never asserted.
5. DIV with div_busy stuck at 0 and DIV_TIMEOUT=40 -> done=1, err=1 at cycle 42 with no HI/LO enables; then req=1, op=5 is accepted normally.
6. Reset and illegal op:
   - rst=1 in DIV_WAIT -> next edge: all outputs 0, IDLE, no write.
   - req with op=7 -> busy stays 0, no done.
